// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if
// Bundles the upstream (in_*) and downstream (out_*) valid/ready/data
// signals of one pipeline stage boundary.
//   slave  : view used by the stage register itself
//            (accepts in_*, produces out_*, drives in_ready)
//   master : view used by the surrounding logic or a testbench
//            (produces in_*, consumes out_*, drives out_ready)
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, ...).
// Carries a DATA_W payload with valid/ready flow control, a synchronous
// flush and a saturating stall-cycle counter.
// With SKID=1 a second (skid) entry lets in_ready come straight from a
// flop, so there is no combinational path from out_ready to in_ready.
// With SKID=0 it is a plain single register with in_ready depending on
// out_ready.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   flush        synchronous flush, discards every held entry
//   bus          slave side of pipe_stage_reg_if (in_* / out_* handshake)
//   occupancy    number of held entries (0..2, max 1 when SKID=0)
//   stall_cycles saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {32'h00400000, 32'h00000000},
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_stage_reg_if.slave    bus,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cycles
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic in_ready;
    logic in_fire;
    logic out_fire;

    // The skid variant only gates its registered ready with flush; the
    // single-register variant must look at out_ready to keep full throughput.
    assign in_ready = (SKID != 0) ? (in_ready_q & ~flush)
                                  : ((~out_valid_q | bus.out_ready) & ~flush);

    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign occupancy     = state_q;
    assign stall_cycles  = stall_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else if (SKID != 0) begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = bus.in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (in_fire) begin
                        // Downstream is stalled: park the new entry behind main.
                        state_d = FULL;
                        skid_d  = bus.in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            if (in_fire) begin
                state_d = ONE;
                main_d  = bus.in_data;
            end else if (out_fire) begin
                state_d = EMPTY;
            end
        end

        // Handshake outputs are registered as a function of the next state.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);

        stall_d = stall_q;
        if (out_valid_q && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= FLUSH_VAL;
            skid_q      <= FLUSH_VAL;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg. u_skid is the SKID=1 stage with a
// 4-bit stall counter (so saturation is reachable); u_noskid is the SKID=0
// stage exercised with random traffic against a one-entry reference model.
// Inputs change 1 ns after the rising edge, outputs are checked 2 ns after.
module tb_pipe_stage_reg;

    localparam logic [63:0] FLUSH = 64'h00400000_00000000;

    logic clk;
    logic reset;
    logic flush_s;
    logic flush_n;
    logic [1:0]  occ_s, occ_n;
    logic [3:0]  stall_s;
    logic [15:0] stall_n;

    int vectors;
    int miscompares;

    pipe_stage_reg_if #(.DATA_W(64)) bus_s ();
    pipe_stage_reg_if #(.DATA_W(64)) bus_n ();

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .CNT_W(4)) u_skid (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush_s),
        .bus          (bus_s),
        .occupancy    (occ_s),
        .stall_cycles (stall_s)
    );

    pipe_stage_reg #(.DATA_W(64), .SKID(0), .CNT_W(16)) u_noskid (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush_n),
        .bus          (bus_n),
        .occupancy    (occ_n),
        .stall_cycles (stall_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // State straight after the power-on reset.
        #1;
        vectors++;
        if (bus_s.out_valid !== 1'b0 || occ_s !== 2'd0 || stall_s !== 4'd0 || bus_s.out_data !== FLUSH) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%0b occ=%0d stall=%0d data=%h expected 0/0/0/%h",
                     bus_s.out_valid, occ_s, stall_s, bus_s.out_data, FLUSH);
        end
        vectors++;
        if (bus_s.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %0b expected 1", bus_s.in_ready);
        end
        // Fill to FULL with A/B, then reset asynchronously mid-cycle.
        bus_s.out_ready = 1'b0;
        bus_s.in_valid  = 1'b1;
        bus_s.in_data   = 64'hA;
        tick();
        bus_s.in_data   = 64'hB;
        tick();
        bus_s.in_valid  = 1'b0;
        #1;
        vectors++;
        if (occ_s !== 2'd2) begin
            miscompares++;
            $display("FAIL reset_prefill_occ: got %0d expected 2", occ_s);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus_s.out_valid !== 1'b0 || occ_s !== 2'd0 || bus_s.out_data !== FLUSH) begin
            miscompares++;
            $display("FAIL reset_midstream: got valid=%0b occ=%0d data=%h expected 0/0/%h",
                     bus_s.out_valid, occ_s, bus_s.out_data, FLUSH);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        bus_s.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus_s.in_valid = 1'b1;
            bus_s.in_data  = 64'(i);
            #1;
            vectors++;
            if (bus_s.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, bus_s.in_ready);
            end
            tick();
            vectors++;
            if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== 64'(i)) begin
                miscompares++;
                $display("FAIL stream_out[%0d]: got valid=%0b data=%h expected 1/%h",
                         i, bus_s.out_valid, bus_s.out_data, 64'(i));
            end
        end
        bus_s.in_valid = 1'b0;
        tick();
        vectors++;
        if (bus_s.out_valid !== 1'b0 || bus_s.out_data !== 64'h8) begin
            miscompares++;
            $display("FAIL stream_drained: got valid=%0b data=%h expected 0/8",
                     bus_s.out_valid, bus_s.out_data);
        end
    endtask

    task automatic test_skid_fill_drain();
        bus_s.out_ready = 1'b0;
        bus_s.in_valid  = 1'b1;
        bus_s.in_data   = 64'hA;
        tick();
        bus_s.in_data   = 64'hB;
        tick();
        bus_s.in_valid  = 1'b0;
        #1;
        vectors++;
        if (occ_s !== 2'd2 || bus_s.in_ready !== 1'b0 || bus_s.out_data !== 64'hA || bus_s.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL skid_full: got occ=%0d rdy=%0b data=%h valid=%0b expected 2/0/a/1",
                     occ_s, bus_s.in_ready, bus_s.out_data, bus_s.out_valid);
        end
        bus_s.out_ready = 1'b1;
        #1;
        vectors++;
        // in_ready must not follow out_ready combinationally.
        if (bus_s.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL skid_ready_path: got %0b expected 0", bus_s.in_ready);
        end
        tick();
        vectors++;
        if (bus_s.out_data !== 64'hB || bus_s.out_valid !== 1'b1 || bus_s.in_ready !== 1'b1 || occ_s !== 2'd1) begin
            miscompares++;
            $display("FAIL skid_drain1: got data=%h valid=%0b rdy=%0b occ=%0d expected b/1/1/1",
                     bus_s.out_data, bus_s.out_valid, bus_s.in_ready, occ_s);
        end
        tick();
        vectors++;
        if (bus_s.out_valid !== 1'b0 || occ_s !== 2'd0 || bus_s.out_data !== 64'hB) begin
            miscompares++;
            $display("FAIL skid_drain2: got valid=%0b occ=%0d data=%h expected 0/0/b",
                     bus_s.out_valid, occ_s, bus_s.out_data);
        end
    endtask

    task automatic test_flush();
        bus_s.out_ready = 1'b0;
        bus_s.in_valid  = 1'b1;
        bus_s.in_data   = 64'h1;
        tick();
        bus_s.in_data   = 64'h2;
        tick();
        flush_s        = 1'b1;
        bus_s.in_data  = 64'hC;
        #1;
        vectors++;
        if (bus_s.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_in_ready: got %0b expected 0", bus_s.in_ready);
        end
        tick();
        flush_s        = 1'b0;
        bus_s.in_valid = 1'b0;
        #1;
        vectors++;
        if (bus_s.out_valid !== 1'b0 || bus_s.out_data !== FLUSH || occ_s !== 2'd0 || bus_s.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_state: got valid=%0b data=%h occ=%0d rdy=%0b expected 0/%h/0/1",
                     bus_s.out_valid, bus_s.out_data, occ_s, bus_s.in_ready, FLUSH);
        end
        bus_s.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus_s.out_valid !== 1'b0 || bus_s.out_data !== FLUSH) begin
                miscompares++;
                $display("FAIL flush_no_leak[%0d]: got valid=%0b data=%h expected 0/%h",
                         i, bus_s.out_valid, bus_s.out_data, FLUSH);
            end
        end
    endtask

    task automatic test_stall_saturation();
        pulse_reset();
        bus_s.out_ready = 1'b0;
        bus_s.in_valid  = 1'b1;
        bus_s.in_data   = 64'h5;
        tick();
        bus_s.in_valid  = 1'b0;
        vectors++;
        if (stall_s !== 4'd0 || bus_s.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_start: got stall=%0d valid=%0b expected 0/1", stall_s, bus_s.out_valid);
        end
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (stall_s !== 4'd5) begin
            miscompares++;
            $display("FAIL stall_count5: got %0d expected 5", stall_s);
        end
        for (int i = 0; i < 15; i++) tick();
        vectors++;
        if (stall_s !== 4'd15 || bus_s.out_data !== 64'h5) begin
            miscompares++;
            $display("FAIL stall_saturate: got stall=%0d data=%h expected 15/5", stall_s, bus_s.out_data);
        end
        flush_s = 1'b1;
        tick();
        flush_s = 1'b0;
        tick();
        vectors++;
        if (stall_s !== 4'd15 || bus_s.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_after_flush: got stall=%0d valid=%0b expected 15/0", stall_s, bus_s.out_valid);
        end
    endtask

    task automatic test_noskid_random();
        logic [63:0] exp_q[$];
        logic        model_valid;
        logic [63:0] model_data;
        logic [63:0] next_val;
        logic        iv, ordy, exp_ready;
        int          delivered;
        model_valid = 1'b0;
        model_data  = FLUSH;
        next_val    = 64'h100;
        delivered   = 0;
        pulse_reset();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            bus_n.in_valid  = iv;
            bus_n.in_data   = next_val;
            bus_n.out_ready = ordy;
            #1;
            exp_ready = ~model_valid | ordy;
            vectors++;
            if (bus_n.in_ready !== exp_ready || bus_n.out_valid !== model_valid) begin
                miscompares++;
                $display("FAIL noskid_hs[%0d]: got rdy=%0b valid=%0b expected %0b/%0b",
                         cyc, bus_n.in_ready, bus_n.out_valid, exp_ready, model_valid);
            end
            vectors++;
            if (bus_n.out_data !== model_data) begin
                miscompares++;
                $display("FAIL noskid_data[%0d]: got %h expected %h", cyc, bus_n.out_data, model_data);
            end
            if (model_valid && ordy) begin
                vectors++;
                if (exp_q.size() == 0 || bus_n.out_data !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL noskid_order[%0d]: got %h expected %h", cyc, bus_n.out_data,
                             (exp_q.size() == 0) ? 64'hx : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                delivered++;
            end
            if (iv && exp_ready) begin
                exp_q.push_back(next_val);
                model_data  = next_val;
                model_valid = 1'b1;
                next_val    = next_val + 64'h1;
            end else if (model_valid && ordy) begin
                model_valid = 1'b0;
            end
            tick();
        end
        bus_n.in_valid = 1'b0;
        vectors++;
        if (delivered < 100) begin
            miscompares++;
            $display("FAIL noskid_delivered: got %0d expected at least 100", delivered);
        end
    endtask

    initial begin
        clk             = 1'b0;
        reset           = 1'b1;
        flush_s         = 1'b0;
        flush_n         = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.in_data   = '0;
        bus_s.out_ready = 1'b0;
        bus_n.in_valid  = 1'b0;
        bus_n.in_data   = '0;
        bus_n.out_ready = 1'b0;
        vectors         = 0;
        miscompares     = 0;
        #12;
        reset = 1'b0;
        tick();
        test_reset();
        test_stream();
        test_skid_fill_drain();
        test_flush();
        test_stall_saturation();
        test_noskid_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
